// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, condition
// codes, status values, the register "none" ID and the E->M register layout.
package y86_pkg;

  localparam int XLEN = 64;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also the cmovXX family
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU functions
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Branch / conditional-move function codes
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Pipeline status
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // Stack pointer adjustment used by call/ret/push/pop
  localparam logic [XLEN-1:0] STACK_STEP = 64'd8;

  // Condition codes after reset: {ZF,SF,OF}
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef struct packed {
    logic [2:0]      stat;
    logic [3:0]      icode;
    logic            cnd;
    logic [XLEN-1:0] val_e;
    logic [XLEN-1:0] val_a;
    logic [3:0]      dst_e;
    logic [3:0]      dst_m;
  } m_reg_t;

  localparam m_reg_t M_BUBBLE = '{
    stat:  S_AOK,
    icode: I_NOP,
    cnd:   1'b0,
    val_e: '0,
    val_a: '0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  // A faulting instruction further down the pipe must not let OPq touch cc
  function automatic logic stat_is_exception(input logic [2:0] s);
    return (s == S_ADR) || (s == S_HLT) || (s == S_INS);
  endfunction

endpackage

// File: rtl/y86_alu.sv
// 64-bit Y86 ALU: ADD, SUB (b - a), AND, XOR with ZF/SF/OF generation.
module y86_alu
  import y86_pkg::*;
(
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [3:0]      alu_fun,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            sf,
  output logic            of
);

  logic [XLEN-1:0] and_vec;
  logic [XLEN-1:0] xor_vec;

  // Bitwise logic slices
  genvar gi;
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_logic
      assign and_vec[gi] = alu_a[gi] & alu_b[gi];
      assign xor_vec[gi] = alu_a[gi] ^ alu_b[gi];
    end
  endgenerate

  // Select the operation and derive signed overflow from operand/result signs
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        result = alu_b + alu_a;
        of     = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (result[XLEN-1] != alu_a[XLEN-1]);
      end
      ALU_SUB: begin
        result = alu_b - alu_a;
        of     = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (result[XLEN-1] != alu_b[XLEN-1]);
      end
      ALU_AND: result = and_vec;
      ALU_XOR: result = xor_vec;
      default: result = '0;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[XLEN-1];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand selection, ALU, condition codes,
// condition evaluation and the E->M pipeline register (negedge clocked).
module execute_stage
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      E_stat,
  input  logic [3:0]      E_icode,
  input  logic [3:0]      E_ifun,
  input  logic [XLEN-1:0] E_valC,
  input  logic [XLEN-1:0] E_valA,
  input  logic [XLEN-1:0] E_valB,
  input  logic [3:0]      E_dstE,
  input  logic [3:0]      E_dstM,
  input  logic [2:0]      m_stat,
  input  logic [2:0]      W_stat,
  input  logic            M_bubble,
  output logic [XLEN-1:0] e_valE,
  output logic [3:0]      e_dstE,
  output logic            e_cnd,
  output logic [2:0]      M_stat,
  output logic [3:0]      M_icode,
  output logic            M_cnd,
  output logic [XLEN-1:0] M_valE,
  output logic [XLEN-1:0] M_valA,
  output logic [3:0]      M_dstE,
  output logic [3:0]      M_dstM,
  output logic [2:0]      cc
);

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_fun;
  logic            alu_zf;
  logic            alu_sf;
  logic            alu_of;
  logic            set_cc;
  logic            cond_true;
  logic [2:0]      cc_reg;
  m_reg_t          m_reg;
  m_reg_t          m_next;

  // Operand A: register, constant, or stack-pointer step
  always_comb begin
    case (E_icode)
      I_RRMOVQ, I_OPQ:            alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:            alu_a = -STACK_STEP;
      I_RET, I_POPQ:              alu_a = STACK_STEP;
      default:                    alu_a = '0;
    endcase
  end

  // Operand B: valB for memory, arithmetic and stack instructions
  always_comb begin
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
      default:                                                  alu_b = '0;
    endcase
  end

  assign alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

  y86_alu u_alu (
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_fun (alu_fun),
    .result  (e_valE),
    .zf      (alu_zf),
    .sf      (alu_sf),
    .of      (alu_of)
  );

  assign set_cc = (E_icode == I_OPQ) && !stat_is_exception(m_stat) && !stat_is_exception(W_stat);

  // Evaluate the branch/move condition against the registered (pre-update) cc
  always_comb begin
    case (E_ifun)
      C_YES:   cond_true = 1'b1;
      C_LE:    cond_true = (cc_reg[1] ^ cc_reg[0]) | cc_reg[2];
      C_L:     cond_true = cc_reg[1] ^ cc_reg[0];
      C_E:     cond_true = cc_reg[2];
      C_NE:    cond_true = !cc_reg[2];
      C_GE:    cond_true = !(cc_reg[1] ^ cc_reg[0]);
      C_G:     cond_true = !(cc_reg[1] ^ cc_reg[0]) && !cc_reg[2];
      default: cond_true = 1'b0;
    endcase
  end

  assign e_cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? cond_true : 1'b1;
  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_cnd) ? RNONE : E_dstE;

  // Next M register contents: the executed instruction or a bubble
  always_comb begin
    if (M_bubble) begin
      m_next = M_BUBBLE;
    end else begin
      m_next.stat  = E_stat;
      m_next.icode = E_icode;
      m_next.cnd   = e_cnd;
      m_next.val_e = e_valE;
      m_next.val_a = E_valA;
      m_next.dst_e = e_dstE;
      m_next.dst_m = E_dstM;
    end
  end

  // Pipeline and condition-code registers; reset overrides bubble and set_cc
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      m_reg  <= M_BUBBLE;
      cc_reg <= CC_RESET;
    end else begin
      m_reg <= m_next;
      if (set_cc) begin
        cc_reg <= {alu_zf, alu_sf, alu_of};
      end
    end
  end

  assign M_stat  = m_reg.stat;
  assign M_icode = m_reg.icode;
  assign M_cnd   = m_reg.cnd;
  assign M_valE  = m_reg.val_e;
  assign M_valA  = m_reg.val_a;
  assign M_dstE  = m_reg.dst_e;
  assign M_dstM  = m_reg.dst_m;
  assign cc      = cc_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Randomised self-checking bench for execute_stage against an arithmetic model.
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valC;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [3:0]  E_dstE;
  logic [3:0]  E_dstM;
  logic [2:0]  m_stat;
  logic [2:0]  W_stat;
  logic        M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_cnd;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [2:0]  cc;

  execute_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .E_stat   (E_stat),
    .E_icode  (E_icode),
    .E_ifun   (E_ifun),
    .E_valC   (E_valC),
    .E_valA   (E_valA),
    .E_valB   (E_valB),
    .E_dstE   (E_dstE),
    .E_dstM   (E_dstM),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .M_bubble (M_bubble),
    .e_valE   (e_valE),
    .e_dstE   (e_dstE),
    .e_cnd    (e_cnd),
    .M_stat   (M_stat),
    .M_icode  (M_icode),
    .M_cnd    (M_cnd),
    .M_valE   (M_valE),
    .M_valA   (M_valA),
    .M_dstE   (M_dstE),
    .M_dstM   (M_dstM),
    .cc       (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Model state: what the M register and cc must hold after the last edge
  bit          mdl_valid = 0;
  logic [2:0]  mdl_cc;
  logic [2:0]  mdl_stat;
  logic [3:0]  mdl_icode;
  logic        mdl_cnd;
  logic [63:0] mdl_valE;
  logic [63:0] mdl_valA;
  logic [3:0]  mdl_dstE;
  logic [3:0]  mdl_dstM;

  // Model combinational expectations for the current inputs
  logic [63:0] exp_valE;
  logic [2:0]  exp_flags;
  logic        exp_cnd;
  logic [3:0]  exp_dstE;
  logic        exp_set_cc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (txn %0d)", name, act, exp, n_txn);
    end
  endtask

  function automatic bit bad_stat(input logic [2:0] s);
    return (s >= 3'd2) && (s <= 3'd4);
  endfunction

  // Behavioural model of the execute stage from the instruction semantics
  task automatic model_comb();
    logic [63:0] a, b, r;
    logic [64:0] w;
    logic [3:0]  fn;
    logic        z, s, o, lt;
    case (E_icode)
      4'h2, 4'h6:       a = E_valA;
      4'h3, 4'h4, 4'h5: a = E_valC;
      4'h8, 4'hA:       a = 64'hFFFF_FFFF_FFFF_FFF8;
      4'h9, 4'hB:       a = 64'd8;
      default:          a = 64'd0;
    endcase
    case (E_icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: b = E_valB;
      default:                                  b = 64'd0;
    endcase
    fn = (E_icode == 4'h6) ? E_ifun : 4'h0;
    o = 1'b0;
    case (fn)
      4'h0: begin
        w = {b[63], b} + {a[63], a};
        r = w[63:0];
        o = w[64] != w[63];
      end
      4'h1: begin
        w = {b[63], b} - {a[63], a};
        r = w[63:0];
        o = w[64] != w[63];
      end
      4'h2:    r = a & b;
      4'h3:    r = a ^ b;
      default: r = 64'd0;
    endcase
    z = (r == 64'd0);
    s = r[63];
    exp_valE  = r;
    exp_flags = {z, s, o};
    lt = mdl_cc[1] ^ mdl_cc[0];
    if (E_icode == 4'h2 || E_icode == 4'h7) begin
      case (E_ifun)
        4'h0:    exp_cnd = 1'b1;
        4'h1:    exp_cnd = lt || mdl_cc[2];
        4'h2:    exp_cnd = lt;
        4'h3:    exp_cnd = mdl_cc[2];
        4'h4:    exp_cnd = !mdl_cc[2];
        4'h5:    exp_cnd = !lt;
        4'h6:    exp_cnd = !lt && !mdl_cc[2];
        default: exp_cnd = 1'b0;
      endcase
    end else begin
      exp_cnd = 1'b1;
    end
    exp_dstE   = (E_icode == 4'h2 && !exp_cnd) ? 4'hF : E_dstE;
    exp_set_cc = (E_icode == 4'h6) && !bad_stat(m_stat) && !bad_stat(W_stat);
  endtask

  task automatic model_bubble();
    mdl_stat  = 3'd1;
    mdl_icode = 4'h1;
    mdl_cnd   = 1'b0;
    mdl_valE  = 64'd0;
    mdl_valA  = 64'd0;
    mdl_dstE  = 4'hF;
    mdl_dstM  = 4'hF;
  endtask

  task automatic check_regs();
    check("M_stat",  {61'd0, M_stat},  {61'd0, mdl_stat});
    check("M_icode", {60'd0, M_icode}, {60'd0, mdl_icode});
    check("M_cnd",   {63'd0, M_cnd},   {63'd0, mdl_cnd});
    check("M_valE",  M_valE,           mdl_valE);
    check("M_valA",  M_valA,           mdl_valA);
    check("M_dstE",  {60'd0, M_dstE},  {60'd0, mdl_dstE});
    check("M_dstM",  {60'd0, M_dstM},  {60'd0, mdl_dstM});
    check("cc",      {61'd0, cc},      {61'd0, mdl_cc});
  endtask

  // One transaction: check registered state, drive inputs, check forwarding, advance model
  task automatic step(input logic rst, input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [63:0] valc, input logic [63:0] vala, input logic [63:0] valb,
                      input logic [3:0] dste, input logic [3:0] dstm, input logic [2:0] estat,
                      input logic [2:0] mst, input logic [2:0] wst, input logic bub);
    @(posedge clk);
    if (mdl_valid) check_regs();
    rst_n    = rst;
    E_icode  = icode;
    E_ifun   = ifun;
    E_valC   = valc;
    E_valA   = vala;
    E_valB   = valb;
    E_dstE   = dste;
    E_dstM   = dstm;
    E_stat   = estat;
    m_stat   = mst;
    W_stat   = wst;
    M_bubble = bub;
    #1;
    model_comb();
    if (mdl_valid) begin
      check("e_valE", e_valE, exp_valE);
      check("e_cnd",  {63'd0, e_cnd},  {63'd0, exp_cnd});
      check("e_dstE", {60'd0, e_dstE}, {60'd0, exp_dstE});
    end
    $display("txn %0d rst_n=%0b bub=%0b icode=%h ifun=%h valA=%h valB=%h valC=%h mst=%0d wst=%0d -> e_valE=%h e_cnd=%0b e_dstE=%h cc=%b",
             n_txn, rst, bub, icode, ifun, vala, valb, valc, mst, wst, e_valE, e_cnd, e_dstE, cc);
    if (!rst) begin
      model_bubble();
      mdl_cc    = 3'b100;
      mdl_valid = 1;
    end else begin
      if (bub) begin
        model_bubble();
      end else begin
        mdl_stat  = estat;
        mdl_icode = icode;
        mdl_cnd   = exp_cnd;
        mdl_valE  = exp_valE;
        mdl_valA  = vala;
        mdl_dstE  = exp_dstE;
        mdl_dstM  = dstm;
      end
      if (exp_set_cc) mdl_cc = exp_flags;
    end
    n_txn++;
  endtask

  task automatic after_edge();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return {59'd0, 5'($urandom)};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; E_stat = 3'd1; E_icode = 4'h1; E_ifun = 4'h0;
    E_valC = '0; E_valA = '0; E_valB = '0; E_dstE = 4'hF; E_dstM = 4'hF;
    m_stat = 3'd1; W_stat = 3'd1; M_bubble = 1'b0;

    // Reset
    step(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1, 3'd1, 3'd1, 1'b0);
    after_edge();
    check("lit_reset_cc",     {61'd0, cc},      64'd4);
    check("lit_reset_M_icode", {60'd0, M_icode}, 64'd1);

    // OPq add 5 + 7
    step(1'b1, 4'h6, 4'h0, 64'd0, 64'd5, 64'd7, 4'h2, 4'hF, 3'd1, 3'd1, 3'd1, 1'b0);
    check("lit_add_valE", e_valE, 64'd12);
    after_edge();
    check("lit_add_cc",     {61'd0, cc}, 64'd0);
    check("lit_add_M_valE", M_valE,      64'd12);

    // OPq sub: 0x8000... - 1 overflows
    step(1'b1, 4'h6, 4'h1, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 4'h2, 4'hF, 3'd1, 3'd1, 3'd1, 1'b0);
    check("lit_sub_valE", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    after_edge();
    check("lit_sub_cc", {61'd0, cc}, 64'd1);

    // OPq while memory stage reports ADR: cc frozen, result still flows
    step(1'b1, 4'h6, 4'h0, 64'd0, 64'd3, 64'd4, 4'h2, 4'hF, 3'd1, 3'd3, 3'd1, 1'b0);
    after_edge();
    check("lit_adr_cc",     {61'd0, cc}, 64'd1);
    check("lit_adr_M_valE", M_valE,      64'd7);

    // 0 - 1 leaves cc = {0,1,0}
    step(1'b1, 4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h2, 4'hF, 3'd1, 3'd1, 3'd1, 1'b0);
    after_edge();
    check("lit_neg_cc", {61'd0, cc}, 64'd2);

    // cmovl taken, cmovge not taken
    step(1'b1, 4'h2, 4'h2, 64'd0, 64'd9, 64'd0, 4'h3, 4'hF, 3'd1, 3'd1, 3'd1, 1'b0);
    check("lit_cmovl_cnd",  {63'd0, e_cnd},  64'd1);
    check("lit_cmovl_dstE", {60'd0, e_dstE}, 64'd3);
    step(1'b1, 4'h2, 4'h5, 64'd0, 64'd9, 64'd0, 4'h3, 4'hF, 3'd1, 3'd1, 3'd1, 1'b0);
    check("lit_cmovge_cnd",  {63'd0, e_cnd},  64'd0);
    check("lit_cmovge_dstE", {60'd0, e_dstE}, 64'd15);

    // pushq / popq stack pointer arithmetic
    step(1'b1, 4'hA, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4, 4'hF, 3'd1, 3'd1, 3'd1, 1'b0);
    check("lit_push_valE", e_valE, 64'hF8);
    step(1'b1, 4'hB, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4, 4'h5, 3'd1, 3'd1, 3'd1, 1'b0);
    check("lit_pop_valE", e_valE, 64'h108);

    // Bubble over a call, then reset over a call
    step(1'b1, 4'h8, 4'h0, 64'h40, 64'd0, 64'h100, 4'h4, 4'hF, 3'd1, 3'd1, 3'd1, 1'b1);
    after_edge();
    check("lit_bub_M_icode", {60'd0, M_icode}, 64'd1);
    check("lit_bub_M_dstE",  {60'd0, M_dstE},  64'd15);
    step(1'b0, 4'h8, 4'h0, 64'h40, 64'd0, 64'h100, 4'h4, 4'hF, 3'd1, 3'd1, 3'd1, 1'b0);
    after_edge();
    check("lit_rst_M_icode", {60'd0, M_icode}, 64'd1);
    check("lit_rst_M_valE",  M_valE,           64'd0);
    check("lit_rst_cc",      {61'd0, cc},      64'd4);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0] mst, wst;
      mst = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      wst = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      step(($urandom_range(0, 49) != 0),
           4'($urandom_range(0, 11)), 4'($urandom_range(0, 7)),
           rand_operand(), rand_operand(), rand_operand(),
           4'($urandom), 4'($urandom), 3'($urandom_range(1, 4)),
           mst, wst, ($urandom_range(0, 7) == 0));
    end

    // Final registered state
    @(posedge clk);
    check_regs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1, pipeline clock; all registers update on negedge clk.
REQ-002 rst_n input 1: synchronous active-low reset, sampled on negedge clk.
REQ-003 E_stat input 3, E_icode input 4, E_ifun input 4: E-register status, opcode and function code.
REQ-004 E_valC, E_valA, E_valB input 64 each: constant and forwarded operands from decode.
REQ-005 E_dstE, E_dstM input 4: destination register IDs; 4'hF = RNONE.
REQ-006 m_stat, W_stat input 3: memory-stage and writeback-stage status, used for CC suppression.
REQ-007 M_bubble input 1: inject a bubble into the M register at the next edge.
REQ-008 e_valE output 64, e_dstE output 4, e_cnd output 1: combinational forwarding outputs to decode.
REQ-009 M_stat output 3, M_icode output 4, M_cnd output 1, M_valE output 64, M_valA output 64, M_dstE output 4, M_dstM output 4: registered E->M pipeline outputs.
REQ-010 cc output 3: registered condition codes {ZF,SF,OF}.

Function
REQ-011 aluA SHALL be: E_valA for icode 2/6; E_valC for icode 3/4/5; -8 for icode 8/A; +8 for icode 9/B; 0 otherwise.
REQ-012 aluB SHALL be: E_valB for icode 4/5/6/8/9/A/B; 0 for icode 2/3 and all others.
REQ-013 alufun SHALL be E_ifun when icode=6, otherwise ADD; codes 0=ADD, 1=SUB (aluB-aluA), 2=AND, 3=XOR; any other ifun produces 0.
REQ-014 e_valE SHALL be the 64-bit result modulo 2^64, with no carry out.
REQ-015 Flags: ZF = result==0; SF = result[63]; OF: ADD -> operands same sign and result sign differs; SUB -> operand signs differ and result sign differs from aluB; AND/XOR -> 0.
REQ-016 set_cc SHALL be (E_icode==6) and m_stat not in {ADR,HLT,INS} and W_stat not in {ADR,HLT,INS}; cc loads the new flags at the edge only when set_cc is asserted.
REQ-017 e_cnd SHALL evaluate E_ifun against the current registered cc: 0 always, 1 LE (SF^OF)|ZF, 2 L SF^OF, 3 E ZF, 4 NE !ZF, 5 GE !(SF^OF), 6 G !(SF^OF)&!ZF, other 0; e_cnd is meaningful for icode 2/7 and is 1 for all other icodes.
REQ-018 e_dstE SHALL be RNONE when E_icode==2 and e_cnd==0, otherwise E_dstE.
REQ-019 When M_bubble=0 the M register SHALL load {E_stat,E_icode,e_cnd,e_valE,E_valA,e_dstE,E_dstM} each edge, a latency of one cycle.
REQ-020 When M_bubble=1 the M register SHALL load the bubble values: stat AOK, icode NOP(1), cnd 0, valE 0, valA 0, dstE and dstM RNONE; cc is still governed by REQ-016.
REQ-021 The cc update SHALL use the current-cycle flags; e_cnd SHALL use the pre-update cc, so a jXX directly after an OPq sees the OPq flags one cycle later.
REQ-022 Status encoding SHALL be AOK=1, HLT=2, ADR=3, INS=4; E_stat SHALL pass through unchanged, with no new exceptions raised in execute.

Reset
REQ-023 With rst_n=0 at an edge, the M register SHALL take the bubble values of REQ-020 and cc SHALL become {ZF=1,SF=0,OF=0}.
REQ-024 Reset SHALL take priority over M_bubble and set_cc; reset mid-stream discards the in-flight instruction.

Structure
REQ-025 The icode/ifun/stat/ALU-op encodings and RNONE SHALL live in a shared package y86_pkg, which fetch, decode and memory also import.
REQ-026 The 64-bit ALU with its flag generation SHALL be a single sub-module y86_alu; the cc register, condition logic and M register SHALL remain in execute_stage.

Verification
REQ-027 Check: OPq add, valA=5, valB=7 -> e_valE=12; after the edge cc={0,0,0} and M_valE=12.
REQ-028 Check: OPq sub, valA=1, valB=0x8000000000000000 -> e_valE=0x7FFFFFFFFFFFFFFF, cc={0,0,1}.
REQ-029 Check: cc={0,1,0}, cmovl (icode 2, ifun 2), dstE=3 -> e_cnd=1 and e_dstE=3; cmovge -> e_cnd=0 and e_dstE=F.
REQ-030 Check: OPq with m_stat=ADR -> cc unchanged and M_valE still updated.
REQ-031 Check: pushq, valB=0x100 -> e_valE=0xF8; popq, valB=0x100 -> e_valE=0x108.
REQ-032 Check: M_bubble=1 during a call -> M_icode=1 and M_dstE=F; rst_n=0 with M_bubble=0 -> bubble values and cc={1,0,0}.
